// File: rtl/icache_pkg.sv
// Shared types and constants for the instruction cache controller.
package icache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS_REQ,
    S_REFILL,
    S_UNC_REQ,
    S_UNC_WAIT,
    S_RESP
  } state_e;

  // Field widths for the default geometry (4 words/line, 128 sets).
  localparam int LINE_WORDS_DEF = 4;
  localparam int SETS_DEF       = 128;
  localparam int OFFSET_W       = $clog2(LINE_WORDS_DEF);
  localparam int INDEX_W        = $clog2(SETS_DEF);
  localparam int TAG_W          = 32 - INDEX_W - OFFSET_W - 2;

  localparam logic [2:0]  KSEG1      = 3'b101;
  localparam logic [31:0] PADDR_MASK = 32'h1FFF_FFFF;

  function automatic logic is_uncached(input logic [31:0] vaddr);
    return vaddr[31:29] == KSEG1;
  endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
module icache_array
  import icache_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 128,
  localparam int OW        = $clog2(LINE_WORDS),
  localparam int IW        = $clog2(SETS),
  localparam int TW        = 32 - IW - OW - 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] i_rd_index,
  input  logic [OW-1:0] i_rd_offset,
  output logic          o_rd_valid,
  output logic [TW-1:0] o_rd_tag,
  output logic [31:0]   o_rd_data,
  input  logic          i_wr_en,
  input  logic [IW-1:0] i_wr_index,
  input  logic [OW-1:0] i_wr_offset,
  input  logic [31:0]   i_wr_data,
  input  logic          i_tag_we,
  input  logic [IW-1:0] i_tag_index,
  input  logic [TW-1:0] i_tag
);

  logic [SETS-1:0] r_valid;
  logic [TW-1:0]   r_tag  [SETS];
  logic [31:0]     r_data [SETS*LINE_WORDS];

  assign o_rd_valid = r_valid[i_rd_index];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_data  = r_data[{i_rd_index, i_rd_offset}];

  // Valid bits: cleared together on reset, set when a line completes refill.
  always_ff @(posedge clk) begin
    if (reset)         r_valid <= '0;
    else if (i_tag_we) r_valid[i_tag_index] <= 1'b1;
  end

  // Tag and data storage need no reset; valid gates their use.
  always_ff @(posedge clk) begin
    if (i_tag_we) r_tag[i_tag_index] <= i_tag;
    if (i_wr_en)  r_data[{i_wr_index, i_wr_offset}] <= i_wr_data;
  end

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller.
// Cache storage and the cached path are built only when ICACHE_EN is defined;
// otherwise every fetch is a single-beat uncached read.
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_cpu_req,
  input  logic [31:0] i_cpu_addr,
  output logic        o_cpu_ready,
  output logic [31:0] o_cpu_inst,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_burst,
  input  logic        i_mem_addr_ok,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_data_ok
);

  state_e      r_state, w_next;
  logic [31:0] r_paddr;
  logic [31:0] r_resp;

`ifdef ICACHE_EN
  localparam int OW = $clog2(LINE_WORDS);
  localparam int IW = $clog2(SETS);
  localparam int TW = 32 - IW - OW - 2;

  logic [OW-1:0] r_beat;
  logic [OW-1:0] w_offset;
  logic [IW-1:0] w_index;
  logic [TW-1:0] w_tag;
  logic          w_rd_valid;
  logic [TW-1:0] w_rd_tag;
  logic [31:0]   w_rd_data;
  logic          w_hit;
  logic          w_beat;
  logic          w_last;

  assign w_offset = r_paddr[OW+1:2];
  assign w_index  = r_paddr[OW+2 +: IW];
  assign w_tag    = r_paddr[31 -: TW];
  assign w_hit    = w_rd_valid && (w_rd_tag == w_tag);
  assign w_beat   = (r_state == S_REFILL) && i_mem_data_ok;
  assign w_last   = w_beat && (r_beat == OW'(LINE_WORDS - 1));

  icache_array #(.LINE_WORDS(LINE_WORDS), .SETS(SETS)) u_array (
    .clk         (clk),
    .reset       (reset),
    .i_rd_index  (w_index),
    .i_rd_offset (w_offset),
    .o_rd_valid  (w_rd_valid),
    .o_rd_tag    (w_rd_tag),
    .o_rd_data   (w_rd_data),
    .i_wr_en     (w_beat),
    .i_wr_index  (w_index),
    .i_wr_offset (r_beat),
    .i_wr_data   (i_mem_rdata),
    .i_tag_we    (w_last),
    .i_tag_index (w_index),
    .i_tag       (w_tag)
  );

  // Refill beat counter; wraps back to zero after the last beat.
  always_ff @(posedge clk) begin
    if (reset)       r_beat <= '0;
    else if (w_beat) r_beat <= r_beat + 1'b1;
  end
`endif

  // State, request address and response word registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_paddr <= '0;
      r_resp  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && i_cpu_req) r_paddr <= i_cpu_addr & PADDR_MASK;
      if (r_state == S_UNC_WAIT && i_mem_data_ok) r_resp <= i_mem_rdata;
`ifdef ICACHE_EN
      if (w_beat && r_beat == w_offset) r_resp <= i_mem_rdata;
`endif
    end
  end

  // Next state and all outputs; outputs idle at zero.
  always_comb begin
    w_next      = r_state;
    o_cpu_ready = 1'b0;
    o_cpu_inst  = '0;
    o_mem_req   = 1'b0;
    o_mem_addr  = '0;
    o_mem_burst = 1'b0;
    case (r_state)
      S_IDLE: begin
`ifdef ICACHE_EN
        if (i_cpu_req) w_next = is_uncached(i_cpu_addr) ? S_UNC_REQ : S_LOOKUP;
`else
        if (i_cpu_req) w_next = S_UNC_REQ;
`endif
      end
`ifdef ICACHE_EN
      S_LOOKUP: begin
        if (w_hit) begin
          o_cpu_ready = 1'b1;
          o_cpu_inst  = w_rd_data;
          w_next      = S_IDLE;
        end else begin
          w_next = S_MISS_REQ;
        end
      end
      S_MISS_REQ: begin
        o_mem_req   = 1'b1;
        o_mem_burst = 1'b1;
        o_mem_addr  = {r_paddr[31:OW+2], {(OW+2){1'b0}}};
        if (i_mem_addr_ok) w_next = S_REFILL;
      end
      S_REFILL: begin
        if (w_last) w_next = S_RESP;
      end
`endif
      S_UNC_REQ: begin
        o_mem_req  = 1'b1;
        o_mem_addr = r_paddr;
        if (i_mem_addr_ok) w_next = S_UNC_WAIT;
      end
      S_UNC_WAIT: begin
        if (i_mem_data_ok) w_next = S_RESP;
      end
      S_RESP: begin
        o_cpu_ready = 1'b1;
        o_cpu_inst  = r_resp;
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed self-checking bench for icache_ctrl (cached or uncached build).
module tb_icache_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic        cpu_ready;
  logic [31:0] cpu_inst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_burst;
  logic        mem_addr_ok;
  logic [31:0] mem_rdata;
  logic        mem_data_ok;

  int n_chk  = 0;
  int n_bad  = 0;
  int n_rdy  = 0;
  int exp_rdy = 0;

  icache_ctrl #(.LINE_WORDS(4), .SETS(128)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_cpu_req     (cpu_req),
    .i_cpu_addr    (cpu_addr),
    .o_cpu_ready   (cpu_ready),
    .o_cpu_inst    (cpu_inst),
    .o_mem_req     (mem_req),
    .o_mem_addr    (mem_addr),
    .o_mem_burst   (mem_burst),
    .i_mem_addr_ok (mem_addr_ok),
    .i_mem_rdata   (mem_rdata),
    .i_mem_data_ok (mem_data_ok)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Every cycle: cpu_inst must read zero whenever cpu_ready is low.
  always @(negedge clk) begin
    if (cpu_ready === 1'b1) n_rdy++;
    else chk("inst_zero", cpu_inst, 32'h0);
  end

  // One fetch served by memory. cached=1 expects LOOKUP then a burst refill.
  // abort_at>=0 pulses reset just before that beat and expects no response.
  task automatic access(input logic [31:0] va, input bit cached, input logic [31:0] exp_addr,
                        input int stall, input logic [31:0] base, input int abort_at);
    int nb;
    logic [31:0] want;
    nb   = cached ? 4 : 1;
    want = cached ? base + 32'((va >> 2) & 3) : base;
    @(negedge clk); cpu_req = 1'b1; cpu_addr = va;
    @(negedge clk); cpu_req = 1'b0;
    if (cached) begin
      chk("lookup_req", {31'b0, mem_req}, 32'h0);
      chk("lookup_rdy", {31'b0, cpu_ready}, 32'h0);
      @(negedge clk);
    end
    chk("req", {31'b0, mem_req}, 32'h1);
    chk("addr", mem_addr, exp_addr);
    chk("burst", {31'b0, mem_burst}, {31'b0, cached});
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_req", {31'b0, mem_req}, 32'h1);
      chk("stall_addr", mem_addr, exp_addr);
    end
    mem_addr_ok = 1'b1;
    @(negedge clk); mem_addr_ok = 1'b0;
    chk("req_drop", {31'b0, mem_req}, 32'h0);
    for (int k = 0; k < nb; k++) begin
      if (k == abort_at) begin
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        chk("abort_rdy", {31'b0, cpu_ready}, 32'h0);
        chk("abort_req", {31'b0, mem_req}, 32'h0);
        return;
      end
      mem_rdata = base + 32'(k); mem_data_ok = 1'b1;
      @(negedge clk); mem_data_ok = 1'b0; mem_rdata = 32'hDEAD_BEEF;
      if (k < nb - 1) chk("beat_rdy", {31'b0, cpu_ready}, 32'h0);
    end
    chk("resp_rdy", {31'b0, cpu_ready}, 32'h1);
    chk("resp_inst", cpu_inst, want);
    exp_rdy++;
    @(negedge clk);
    chk("resp_pulse", {31'b0, cpu_ready}, 32'h0);
  endtask

  // A fetch that must hit: ready the cycle after the request, no memory traffic.
  task automatic hit(input logic [31:0] va, input logic [31:0] want);
    @(negedge clk); cpu_req = 1'b1; cpu_addr = va;
    @(negedge clk); cpu_req = 1'b0;
    chk("hit_rdy", {31'b0, cpu_ready}, 32'h1);
    chk("hit_inst", cpu_inst, want);
    chk("hit_noreq", {31'b0, mem_req}, 32'h0);
    exp_rdy++;
    @(negedge clk);
    chk("hit_pulse", {31'b0, cpu_ready}, 32'h0);
  endtask

  initial begin
    reset = 1'b1; cpu_req = 1'b0; cpu_addr = '0;
    mem_addr_ok = 1'b0; mem_rdata = '0; mem_data_ok = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rdy",   {31'b0, cpu_ready}, 32'h0);
    chk("rst_inst",  cpu_inst, 32'h0);
    chk("rst_req",   {31'b0, mem_req}, 32'h0);
    chk("rst_burst", {31'b0, mem_burst}, 32'h0);
    chk("rst_addr",  mem_addr, 32'h0);
    reset = 1'b0;

    // kseg1 boot fetch is uncached in every build
    access(32'hBFC0_0000, 1'b0, 32'h1FC0_0000, 0, 32'h3C08_8000, -1);

`ifdef ICACHE_EN
    access(32'h8000_1004, 1'b1, 32'h0000_1000, 0, 32'hA000_0000, -1);
    hit(32'h8000_1008, 32'hA000_0002);
    access(32'h8000_3004, 1'b1, 32'h0000_3000, 0, 32'hB000_0000, -1);
    access(32'h8000_1004, 1'b1, 32'h0000_1000, 0, 32'hC000_0000, -1);
    hit(32'h8000_100C, 32'hC000_0003);
    access(32'h8000_001C, 1'b1, 32'h0000_0010, 5, 32'hD000_0000, -1);
    access(32'h8000_0020, 1'b1, 32'h0000_0020, 0, 32'hE000_0000, 2);
    access(32'h8000_0020, 1'b1, 32'h0000_0020, 0, 32'hF000_0000, -1);
    hit(32'h8000_0024, 32'hF000_0001);
`else
    access(32'h8000_1004, 1'b0, 32'h0000_1004, 0, 32'hA000_0001, -1);
    access(32'h8000_1004, 1'b0, 32'h0000_1004, 0, 32'hA100_0001, -1);
    access(32'h0040_0008, 1'b0, 32'h0040_0008, 5, 32'hD000_0000, -1);
    access(32'hA000_0100, 1'b0, 32'h0000_0100, 0, 32'hE000_0000, 0);
    access(32'hA000_0100, 1'b0, 32'h0000_0100, 0, 32'hF000_0000, -1);
`endif

    repeat (3) @(negedge clk);
    chk("rdy_count", 32'(n_rdy), 32'(exp_rdy));
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
